// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO family.
// ptr_next wraps at an arbitrary depth, so pointer logic never relies on power-of-two rollover.
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH flop array: one synchronous write port, one asynchronous read port.
// Contents are deliberately left unreset.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with any depth >= 2, standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds and sticky overflow/underflow flags.
module sync_fifo_fwft #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);
  import fifo_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be >= 2");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
    $error("sync_fifo_fwft: FWFT must be 0 or 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_fwft: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_fwft: AE_LEVEL out of range 0..DEPTH-1");
  end
  if (CNT_W != $clog2(DEPTH + 1)) begin : g_bad_cnt
    $error("sync_fifo_fwft: CNT_W must not be overridden");
  end

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] level_reg;
  logic             overflow_reg, underflow_reg;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] mem_rd_data;

  // Status is decoded only from registered level, keeping inputs off output paths.
  assign level        = level_reg;
  assign full         = (level_reg == CNT_W'(DEPTH));
  assign empty        = (level_reg == '0);
  assign almost_full  = (level_reg >= CNT_W'(AF_LEVEL));
  assign almost_empty = (level_reg <= CNT_W'(AE_LEVEL));
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // No full-bypass: a simultaneous read never makes room for a write at full.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (mem_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= PTR_W'(ptr_next(32'(wr_ptr_reg), DEPTH));
      end
      if (rd_ok) begin
        rd_ptr_reg <= PTR_W'(ptr_next(32'(rd_ptr_reg), DEPTH));
      end
      if (wr_ok && !rd_ok) begin
        level_reg <= level_reg + CNT_W'(1);
      end else if (rd_ok && !wr_ok) begin
        level_reg <= level_reg - CNT_W'(1);
      end
      // A new error in the clearing cycle wins over clr_err.
      overflow_reg  <= (wr_en & full)  | (overflow_reg  & ~clr_err);
      underflow_reg <= (rd_en & empty) | (underflow_reg & ~clr_err);
    end
  end

  if (MODE == fifo_pkg::FWFT) begin : g_fwft
    assign rd_data = mem_rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_reg;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_reg <= '0;
      end else if (rd_ok) begin
        rd_data_reg <= mem_rd_data;
      end
    end
    assign rd_data = rd_data_reg;
  end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench for sync_fifo_fwft: standard DEPTH=64, standard DEPTH=5 and FWFT DEPTH=64
// instances, exercised one at a time through a shared reference queue.
module tb_sync_fifo_fwft;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wr_en[3], rd_en[3], clr_err[3];
  logic [7:0] wr_data[3], rd_data[3];
  logic       full[3], empty[3], af[3], ae[3], ov[3], uf[3];
  logic [6:0] level_a, level_c;
  logic [2:0] level_b;
  logic [6:0] lvl[3];

  assign lvl[0] = level_a;
  assign lvl[1] = {4'b0, level_b};
  assign lvl[2] = level_c;

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(64), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .rd_en(rd_en[0]),
    .rd_data(rd_data[0]), .full(full[0]), .empty(empty[0]), .almost_full(af[0]),
    .almost_empty(ae[0]), .level(level_a), .overflow(ov[0]), .underflow(uf[0]),
    .clr_err(clr_err[0]));

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_np2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .rd_en(rd_en[1]),
    .rd_data(rd_data[1]), .full(full[1]), .empty(empty[1]), .almost_full(af[1]),
    .almost_empty(ae[1]), .level(level_b), .overflow(ov[1]), .underflow(uf[1]),
    .clr_err(clr_err[1]));

  sync_fifo_fwft #(.WIDTH(8), .DEPTH(64), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]), .rd_en(rd_en[2]),
    .rd_data(rd_data[2]), .full(full[2]), .empty(empty[2]), .almost_full(af[2]),
    .almost_empty(ae[2]), .level(level_c), .overflow(ov[2]), .underflow(uf[2]),
    .clr_err(clr_err[2]));

  int         cur, dep, mlev;
  logic [7:0] sb[$];
  logic [7:0] exp_rd;
  bit         exp_ov, exp_uf;
  int         checks = 0;
  int         errors = 0;

  task automatic do_reset(input int k);
    cur = k;
    dep = (k == 1) ? 5 : 64;
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 1'b0; rd_en[i] = 1'b0; clr_err[i] = 1'b0; wr_data[i] = 8'h00;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    mlev = 0; exp_rd = 8'h00; exp_ov = 1'b0; exp_uf = 1'b0;
  endtask

  // Drives one cycle on the active instance and advances the reference model.
  task automatic cycle(input bit wr, input bit rd, input bit clr, input logic [7:0] d);
    bit wacc, racc;
    wr_en[cur] = wr; rd_en[cur] = rd; clr_err[cur] = clr; wr_data[cur] = d;
    @(posedge clk);
    wacc = wr && (mlev < dep);
    racc = rd && (mlev > 0);
    if (clr) begin exp_ov = 1'b0; exp_uf = 1'b0; end
    if (wr && !wacc) exp_ov = 1'b1;
    if (rd && !racc) exp_uf = 1'b1;
    if (racc) exp_rd = sb.pop_front();
    if (wacc) sb.push_back(d);
    mlev = mlev + int'(wacc) - int'(racc);
    #1;
    wr_en[cur] = 1'b0; rd_en[cur] = 1'b0; clr_err[cur] = 1'b0;
    $display("t=%0t inst=%0d wr=%0d rd=%0d clr=%0d din=%02h dout=%02h lvl=%0d", $time, cur,
             wr, rd, clr, d, rd_data[cur], lvl[cur]);
  endtask

  task automatic test_reset();
    do_reset(0);
    checks++; if (lvl[0] !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", lvl[0]); end
    checks++; if (empty[0] !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty[0]); end
    checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full[0]); end
    checks++; if (ae[0] !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b want 1", ae[0]); end
    checks++; if (af[0] !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b want 0", af[0]); end
    checks++; if (ov[0] !== 1'b0 || uf[0] !== 1'b0) begin errors++; $display("FAIL reset_errs: got ov=%b uf=%b want 0 0", ov[0], uf[0]); end
    checks++; if (rd_data[0] !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %02h want 00", rd_data[0]); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'(i));
      checks++; if (lvl[0] !== 7'(i + 1)) begin errors++; $display("FAIL fill_level: got %0d want %0d", lvl[0], i + 1); end
      checks++; if (af[0] !== (i + 1 >= 60)) begin errors++; $display("FAIL fill_almost_full: level %0d got %b want %b", i + 1, af[0], (i + 1 >= 60)); end
      checks++; if (full[0] !== (i + 1 == 64)) begin errors++; $display("FAIL fill_full: level %0d got %b want %b", i + 1, full[0], (i + 1 == 64)); end
      checks++; if (ae[0] !== (i + 1 <= 4)) begin errors++; $display("FAIL fill_almost_empty: level %0d got %b want %b", i + 1, ae[0], (i + 1 <= 4)); end
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 1'b0, 8'hAA);
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ov[0]); end
    checks++; if (lvl[0] !== 7'd64) begin errors++; $display("FAIL ovf_level: got %0d want 64", lvl[0]); end
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      checks++; if (rd_data[0] !== exp_rd) begin errors++; $display("FAIL drain_data: idx %0d got %02h want %02h", i, rd_data[0], exp_rd); end
    end
    checks++; if (empty[0] !== 1'b1 || lvl[0] !== 7'd0) begin errors++; $display("FAIL drain_empty: got empty=%b level=%0d want 1 0", empty[0], lvl[0]); end
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ov[0]); end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (uf[0] !== 1'b1) begin errors++; $display("FAIL udf_flag: got %b want 1", uf[0]); end
    checks++; if (rd_data[0] !== 8'h3F) begin errors++; $display("FAIL udf_rd_hold: got %02h want 3f", rd_data[0]); end
    checks++; if (lvl[0] !== 7'd0) begin errors++; $display("FAIL udf_level: got %0d want 0", lvl[0]); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    checks++; if (uf[0] !== 1'b0 || ov[0] !== 1'b0) begin errors++; $display("FAIL clr_err: got uf=%b ov=%b want 0 0", uf[0], ov[0]); end
    cycle(1'b0, 1'b1, 1'b1, 8'h00);
    checks++; if (uf[0] !== exp_uf || uf[0] !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got uf=%b want 1", uf[0]); end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  // Pointers are steered to 59/62 first so the steady-state run crosses the 63->0 wrap.
  task automatic test_back_to_back();
    cycle(1'b1, 1'b0, 1'b0, 8'h40);
    for (int i = 0; i < 59; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'(8'h41 + i));
      checks++; if (rd_data[0] !== exp_rd || lvl[0] !== 7'd1) begin errors++; $display("FAIL b2b_prep: got %02h/%0d want %02h/1", rd_data[0], lvl[0], exp_rd); end
    end
    cycle(1'b1, 1'b0, 1'b0, 8'hB0);
    cycle(1'b1, 1'b0, 1'b0, 8'hB1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
      checks++; if (lvl[0] !== 7'd3) begin errors++; $display("FAIL b2b_level: got %0d want 3", lvl[0]); end
      checks++; if (rd_data[0] !== exp_rd) begin errors++; $display("FAIL b2b_data: got %02h want %02h", rd_data[0], exp_rd); end
    end
  endtask

  task automatic test_nonpow2();
    bit w, r;
    int wcnt;
    do_reset(1);
    checks++; if (lvl[0] !== 7'd0 || empty[0] !== 1'b1) begin errors++; $display("FAIL reset_mid_op: got level=%0d empty=%b want 0 1", lvl[0], empty[0]); end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    checks++; if (full[1] !== 1'b1 || lvl[1] !== 7'd5) begin errors++; $display("FAIL np2_full: got full=%b level=%0d want 1 5", full[1], lvl[1]); end
    cycle(1'b1, 1'b1, 1'b0, 8'hEE);
    checks++; if (ov[1] !== 1'b1 || lvl[1] !== 7'd4) begin errors++; $display("FAIL no_bypass: got ov=%b level=%0d want 1 4", ov[1], lvl[1]); end
    checks++; if (rd_data[1] !== exp_rd) begin errors++; $display("FAIL np2_first: got %02h want %02h", rd_data[1], exp_rd); end
    wcnt = 5;
    for (int s = 0; s < 300 && (wcnt < 23 || mlev > 0); s++) begin
      w = (wcnt < 23) && (mlev < 5) && ($urandom_range(0, 3) != 0);
      r = (mlev > 0) && ($urandom_range(0, 2) != 0);
      cycle(w, r, 1'b0, 8'(8'h60 + wcnt));
      if (w) wcnt++;
      if (r) begin
        checks++; if (rd_data[1] !== exp_rd) begin errors++; $display("FAIL np2_data: got %02h want %02h", rd_data[1], exp_rd); end
      end
      checks++; if (lvl[1] !== 7'(mlev)) begin errors++; $display("FAIL np2_level: got %0d want %0d", lvl[1], mlev); end
    end
    checks++; if (empty[1] !== 1'b1 || uf[1] !== 1'b0) begin errors++; $display("FAIL np2_end: got empty=%b uf=%b want 1 0", empty[1], uf[1]); end
  endtask

  task automatic test_fwft();
    do_reset(2);
    cycle(1'b1, 1'b0, 1'b0, 8'h11);
    checks++; if (rd_data[2] !== 8'h11) begin errors++; $display("FAIL fwft_data: got %02h want 11", rd_data[2]); end
    checks++; if (empty[2] !== 1'b0 || lvl[2] !== 7'd1) begin errors++; $display("FAIL fwft_nonempty: got empty=%b level=%0d want 0 1", empty[2], lvl[2]); end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    checks++; if (empty[2] !== 1'b1) begin errors++; $display("FAIL fwft_pop_empty: got %b want 1", empty[2]); end
    cycle(1'b1, 1'b0, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 1'b0, 8'h33);
    cycle(1'b1, 1'b0, 1'b0, 8'h44);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_data[2] !== sb[0]) begin errors++; $display("FAIL fwft_head: got %02h want %02h", rd_data[2], sb[0]); end
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
    end
    checks++; if (empty[2] !== 1'b1 || uf[2] !== 1'b0) begin errors++; $display("FAIL fwft_drain: got empty=%b uf=%b want 1 0", empty[2], uf[2]); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_underflow();
    test_back_to_back();
    test_nonpow2();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
